contador_universal_mod: RTL and testbench

- Parametrised successor of the team's N-bit universal up/down counter.
- Adds programmable lower/upper bounds, programmable step, wrap-or-saturate mode, registered event ticks and a sticky overflow flag.
- Used as the generic timebase/index counter in FPGA datapaths: baud dividers, address generators and frame counters.

---
 rtl/contador_universal_mod.sv | 106 ++++++++++
 tb/tb_contador_universal_mod.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/contador_universal_mod.sv
// Bounded up/down counter with programmable step, wrap-or-saturate mode,
// registered wrap/saturation pulses and a sticky overflow flag.
module contador_universal_mod #(
  parameter int N       = 8,
  parameter int STEP_W  = 4,
  parameter int RST_VAL = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syn_clr,
  input  logic              load,
  input  logic              en,
  input  logic              up,
  input  logic              sat_mode,
  input  logic [STEP_W-1:0] step,
  input  logic [N-1:0]      lo,
  input  logic [N-1:0]      hi,
  input  logic [N-1:0]      d,
  input  logic              ovf_clr,
  output logic [N-1:0]      q,
  output logic              max_tick,
  output logic              min_tick,
  output logic              wrap_tick,
  output logic              sat_flag,
  output logic              ovf,
  output logic              cfg_err
);

  // One guard bit above the wider of q and step so sums never alias.
  localparam int W = ((STEP_W > N) ? STEP_W : N) + 1;
  localparam logic [N-1:0] RST_Q = RST_VAL[N-1:0];

  logic [N-1:0] q_q, q_d;
  logic         wrap_q, wrap_d;
  logic         sat_q, sat_d;
  logic         ovf_q, ovf_d;
  logic         evt;

  logic [W-1:0] q_ext, step_ext, lo_ext, hi_ext;
  logic [W-1:0] up_sum, dn_floor;

  assign q_ext    = W'(q_q);
  assign step_ext = W'(step);
  assign lo_ext   = W'(lo);
  assign hi_ext   = W'(hi);
  assign up_sum   = q_ext + step_ext;
  // q - step >= lo is evaluated as q >= lo + step to stay unsigned.
  assign dn_floor = lo_ext + step_ext;

  assign cfg_err = (lo > hi);

  always_comb begin
    q_d = q_q;
    evt = 1'b0;
    if (syn_clr) begin
      q_d = lo;
    end else if (load) begin
      if (cfg_err)     q_d = d;
      else if (d < lo) q_d = lo;
      else if (d > hi) q_d = hi;
      else             q_d = d;
    end else if (!cfg_err && en && (step != '0)) begin
      if (up) begin
        if (up_sum > hi_ext) begin
          evt = 1'b1;
          q_d = sat_mode ? hi : lo;
        end else begin
          q_d = up_sum[N-1:0];
        end
      end else begin
        if (q_ext < dn_floor) begin
          evt = 1'b1;
          q_d = sat_mode ? lo : hi;
        end else begin
          q_d = N'(q_ext - step_ext);
        end
      end
    end
    wrap_d = evt & ~sat_mode;
    sat_d  = evt & sat_mode;
    // A new event outranks a simultaneous clear request.
    ovf_d  = evt | (ovf_q & ~ovf_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_q    <= RST_Q;
      wrap_q <= 1'b0;
      sat_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      sat_q  <= sat_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q         = q_q;
  assign wrap_tick = wrap_q;
  assign sat_flag  = sat_q;
  assign ovf       = ovf_q;
  assign max_tick  = (q_q == hi);
  assign min_tick  = (q_q == lo);

endmodule

// File: tb/tb_contador_universal_mod.sv
// Scoreboard bench: the driver predicts each edge with an integer model and
// queues it; the monitor pops and compares one entry after every rising edge.
module tb_contador_universal_mod;
  localparam int N   = 8;
  localparam int SW  = 4;
  localparam int RST = 0;
  localparam int EW  = N + 6;

  logic          clk, reset, syn_clr, load, en, up, sat_mode, ovf_clr;
  logic [SW-1:0] step;
  logic [N-1:0]  lo, hi, d, q;
  logic          max_tick, min_tick, wrap_tick, sat_flag, ovf, cfg_err;

  int vecs = 0;
  int errs = 0;
  logic [EW-1:0] exp_q[$];

  int mq = RST;
  bit mw = 1'b0, ms = 1'b0, mo = 1'b0;

  contador_universal_mod #(.N(N), .STEP_W(SW), .RST_VAL(RST)) dut (
    .clk(clk), .reset(reset), .syn_clr(syn_clr), .load(load), .en(en),
    .up(up), .sat_mode(sat_mode), .step(step), .lo(lo), .hi(hi), .d(d),
    .ovf_clr(ovf_clr), .q(q), .max_tick(max_tick), .min_tick(min_tick),
    .wrap_tick(wrap_tick), .sat_flag(sat_flag), .ovf(ovf), .cfg_err(cfg_err)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver: set inputs, advance the model by one edge, queue the prediction
  task automatic apply(input bit sc, ld, e, u, sm, input int st, l, h, dd,
                       input bit oc);
    bit ev;
    syn_clr = sc; load = ld; en = e; up = u; sat_mode = sm; ovf_clr = oc;
    step = st[SW-1:0]; lo = l[N-1:0]; hi = h[N-1:0]; d = dd[N-1:0];
    ev = 1'b0;
    if (sc) mq = l;
    else if (ld) begin
      if (l > h)       mq = dd;
      else if (dd < l) mq = l;
      else if (dd > h) mq = h;
      else             mq = dd;
    end else if (l <= h && e && st != 0) begin
      if (u) begin
        if (mq + st > h) begin ev = 1'b1; mq = sm ? h : l; end
        else mq = mq + st;
      end else begin
        if (mq - st < l) begin ev = 1'b1; mq = sm ? l : h; end
        else mq = mq - st;
      end
    end
    mw = ev && !sm;
    ms = ev && sm;
    mo = ev ? 1'b1 : (oc ? 1'b0 : mo);
    exp_q.push_back({mq[N-1:0], mw, ms, mo, (mq == h), (mq == l), (l > h)});
  endtask

  task automatic cyc(input bit sc, ld, e, u, sm, input int st, l, h, dd,
                     input bit oc);
    @(negedge clk);
    apply(sc, ld, e, u, sm, st, l, h, dd, oc);
  endtask

  task automatic rst_check(input string name);
    vecs++;
    if ({q, wrap_tick, sat_flag, ovf} !== {RST[N-1:0], 3'b000}) begin
      errs++;
      $display("FAIL %s: q=%0d w/s/o=%b%b%b, expected q=%0d w/s/o=000",
               name, q, wrap_tick, sat_flag, ovf, RST);
    end
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #1 reset = 1'b0;
    #1 rst_check("reset_async");
    syn_clr = 1'b0; load = 1'b0; en = 1'b0; ovf_clr = 1'b0;
    reset = 1'b1;
    mq = RST; mw = 1'b0; ms = 1'b0; mo = 1'b0;
  endtask

  // monitor
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        vecs++;
        if (q !== e[EW-1:6]) begin
          errs++;
          $display("FAIL q @%0t: got %0d, expected %0d", $time, q, e[EW-1:6]);
        end
        vecs++;
        if ({wrap_tick, sat_flag, ovf, max_tick, min_tick, cfg_err} !== e[5:0]) begin
          errs++;
          $display("FAIL flags(wrap,sat,ovf,max,min,cfg) @%0t: got %b, expected %b",
                   $time, {wrap_tick, sat_flag, ovf, max_tick, min_tick, cfg_err}, e[5:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    errs++;
    $display("FAIL watchdog: run did not complete, %0d predictions pending", exp_q.size());
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    reset = 1'b0; syn_clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1;
    sat_mode = 1'b0; ovf_clr = 1'b0; step = '0; lo = '0; hi = 8'd255; d = '0;
    #12 rst_check("reset_init");
    #1 reset = 1'b1;

    // full-range wrap
    repeat (257) cyc(0, 0, 1, 1, 0, 1, 0, 255, 0, 0);
    // saturating up, step 3
    cyc(0, 1, 0, 1, 1, 3, 10, 20, 10, 0);
    repeat (6) cyc(0, 0, 1, 1, 1, 3, 10, 20, 0, 0);
    // wrapping down, step 4
    cyc(0, 1, 0, 0, 0, 4, 10, 20, 12, 0);
    repeat (2) cyc(0, 0, 1, 0, 0, 4, 10, 20, 0, 0);
    // load clamping and clear priority
    cyc(0, 1, 0, 1, 0, 1, 10, 20, 5, 0);
    cyc(0, 1, 0, 1, 0, 1, 10, 20, 30, 0);
    cyc(1, 1, 1, 1, 0, 1, 10, 20, 15, 0);
    // inverted bounds: hold, unclamped load
    repeat (3) cyc(0, 0, 1, 1, 0, 5, 50, 40, 0, 0);
    cyc(0, 1, 0, 1, 0, 5, 50, 40, 77, 0);
    // wide-step wrap lands on lo; set beats clear; clear alone
    cyc(0, 1, 0, 1, 0, 1, 0, 255, 254, 0);
    cyc(0, 0, 1, 1, 0, 15, 0, 255, 0, 1);
    cyc(0, 0, 0, 1, 0, 1, 0, 255, 0, 1);
    // step 0 holds; out-of-range q after a bound change
    cyc(0, 0, 1, 1, 1, 0, 0, 255, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0, 255, 200, 0);
    cyc(0, 0, 1, 1, 1, 1, 0, 100, 0, 0);
    cyc(0, 1, 0, 1, 0, 1, 0, 255, 5, 0);
    cyc(0, 0, 1, 0, 0, 2, 30, 90, 0, 0);
    cyc(0, 0, 1, 1, 1, 0, 30, 30, 0, 0);
    // async reset mid-count, then resume
    repeat (5) cyc(0, 0, 1, 1, 0, 7, 0, 255, 0, 0);
    reset_mid();
    repeat (3) cyc(0, 0, 1, 1, 0, 1, 0, 255, 0, 0);

    // randomized traffic
    begin
      int l, h, t;
      l = 0; h = 255;
      for (int i = 0; i < 500; i++) begin
        if (i % 16 == 0) begin
          l = $urandom_range(0, 200);
          h = $urandom_range(l, 255);
          if ($urandom_range(0, 9) == 0) begin t = l; l = h; h = t; end
        end
        cyc($urandom_range(0, 31) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
            $urandom_range(0, 1) == 1, $urandom_range(0, 15),
            l, h, $urandom_range(0, 255), $urandom_range(0, 7) == 0);
        if (i == 250) reset_mid();
      end
    end

    repeat (3) @(negedge clk);
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL drain: %0d predictions unchecked, expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
